// File: rtl/muldiv_sequencer.sv
// Sequencer for the shared multi-cycle mult/div units: issues the start pulse, waits for the
// selected unit's stop flag, then loads Hi/Lo or reports divide-by-zero / timeout.
module muldiv_sequencer #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic req_mult,
  input  logic req_div,
  input  logic abort,
  input  logic mult_stop,
  input  logic div_stop,
  input  logic div_zero,
  output logic mult_control,
  output logic div_control,
  output logic sel_mux_hi,
  output logic sel_mux_lo,
  output logic HiLo_load,
  output logic busy,
  output logic done,
  output logic div_zero_exc,
  output logic timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN_MULT,
    S_RUN_DIV,
    S_LOAD,
    S_DONE,
    S_EXC
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);

  state_t           state_reg, state_next;
  logic             op_mult_reg, op_mult_next;
  logic             exc_zero_reg, exc_zero_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             unit_stop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      op_mult_reg  <= 1'b0;
      exc_zero_reg <= 1'b0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      op_mult_reg  <= op_mult_next;
      exc_zero_reg <= exc_zero_next;
      count_reg    <= count_next;
    end
  end

  // Only the selected unit's stop flag can end the run.
  assign unit_stop = op_mult_reg ? mult_stop : div_stop;

  always_comb begin
    state_next    = state_reg;
    op_mult_next  = op_mult_reg;
    exc_zero_next = exc_zero_reg;
    count_next    = count_reg;
    case (state_reg)
      S_IDLE: begin
        count_next = '0;
        if (req_mult) begin
          op_mult_next = 1'b1;
          state_next   = S_START;
        end else if (req_div) begin
          op_mult_next = 1'b0;
          state_next   = S_START;
        end
      end
      S_START: begin
        count_next = '0;
        state_next = op_mult_reg ? S_RUN_MULT : S_RUN_DIV;
      end
      S_RUN_MULT, S_RUN_DIV: begin
        if (count_reg != CNT_SAT) begin
          count_next = count_reg + 1'b1;
        end
        if (abort) begin
          state_next = S_IDLE;
        end else if (state_reg == S_RUN_DIV && div_zero) begin
          exc_zero_next = 1'b1;
          state_next    = S_EXC;
        end else if (unit_stop) begin
          state_next = S_LOAD;
        end else if (count_reg == CNT_LAST) begin
          exc_zero_next = 1'b0;
          state_next    = S_EXC;
        end
      end
      S_LOAD:  state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      S_EXC:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Moore decode; sel_mux_* follow the recorded op everywhere except IDLE.
  always_comb begin
    mult_control = 1'b0;
    div_control  = 1'b0;
    HiLo_load    = 1'b0;
    done         = 1'b0;
    div_zero_exc = 1'b0;
    timeout_err  = 1'b0;
    busy         = (state_reg != S_IDLE);
    sel_mux_hi   = busy && op_mult_reg;
    sel_mux_lo   = busy && op_mult_reg;
    case (state_reg)
      S_START: begin
        mult_control = op_mult_reg;
        div_control  = !op_mult_reg;
      end
      S_LOAD:  HiLo_load = 1'b1;
      S_DONE:  done = 1'b1;
      S_EXC: begin
        div_zero_exc = exc_zero_reg;
        timeout_err  = !exc_zero_reg;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: transaction-level timeline model plus hand-pinned cycles.
module tb_muldiv_sequencer;
  localparam int TIMEOUT = 40;
  localparam int CNT_W   = 6;
  localparam int MAXC    = 8192;
  localparam int K_ABORT = 0, K_ZERO = 1, K_STOP = 2, K_TOUT = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req_mult, req_div, abort, mult_stop, div_stop, div_zero;
  logic mult_control, div_control, sel_mux_hi, sel_mux_lo, HiLo_load;
  logic busy, done, div_zero_exc, timeout_err;

  always #5 clk = ~clk;

  muldiv_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .req_mult(req_mult), .req_div(req_div), .abort(abort),
    .mult_stop(mult_stop), .div_stop(div_stop), .div_zero(div_zero),
    .mult_control(mult_control), .div_control(div_control),
    .sel_mux_hi(sel_mux_hi), .sel_mux_lo(sel_mux_lo), .HiLo_load(HiLo_load),
    .busy(busy), .done(done), .div_zero_exc(div_zero_exc), .timeout_err(timeout_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected output vector per cycle: {mult_ctl, div_ctl, sel_hi, sel_lo, load, busy, done, zero, tout}
  bit [8:0] exp_v [MAXC];
  bit [8:0] pin_v [MAXC];
  bit       pin_on [MAXC];
  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] dut_v;
  assign dut_v = {mult_control, div_control, sel_mux_hi, sel_mux_lo, HiLo_load,
                  busy, done, div_zero_exc, timeout_err};

  always @(negedge clk) begin
    int add_c;
    int add_f;
    add_c = 0;
    add_f = 0;
    if (cyc < MAXC) begin
      add_c = add_c + 1;
      if (dut_v !== exp_v[cyc]) begin
        add_f = add_f + 1;
        $display("FAIL model cycle %0d: outputs got %b required %b", cyc, dut_v, exp_v[cyc]);
      end
      if (pin_on[cyc]) begin
        add_c = add_c + 1;
        if (dut_v !== pin_v[cyc]) begin
          add_f = add_f + 1;
          $display("FAIL pinned cycle %0d: outputs got %b required %b", cyc, dut_v, pin_v[cyc]);
        end
      end
    end
    n_checks <= n_checks + add_c;
    n_fail   <= n_fail + add_f;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic bit [8:0] pk(input bit mc, input bit dc, input bit sel, input bit ld,
                                  input bit bz, input bit dn, input bit dz, input bit to);
    return {mc, dc, sel, sel, ld, bz, dn, dz, to};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input int c, input bit [8:0] v);
    pin_v[c]  = v;
    pin_on[c] = 1'b1;
  endtask

  task automatic quiet();
    req_mult = 0; req_div = 0; abort = 0; mult_stop = 0; div_stop = 0; div_zero = 0;
  endtask

  task automatic idle_noise();
    req_mult = 0; req_div = 0;
    abort = rb(); mult_stop = rb(); div_stop = rb(); div_zero = rb();
  endtask

  task automatic busy_noise();
    req_mult = rb(); req_div = rb();
    abort = rb(); mult_stop = rb(); div_stop = rb(); div_zero = rb();
  endtask

  // One operation: j_* are RUN-cycle numbers (1 = first RUN cycle) of each event, 0 = never.
  task automatic run_txn(input bit rq_m, input bit rq_d, input int j_stop, input int j_zero,
                         input int j_abort, input bit force_noise, input int gap, output int r);
    bit op;
    int e, kind, s, post;
    string kn;
    for (int g = 0; g < gap; g++) begin
      idle_noise();
      next_cycle();
    end
    r = cyc;
    s = r + 1;
    idle_noise();
    req_mult = rq_m;
    req_div  = rq_d;
    op = rq_m;
    kind = K_TOUT;
    e = TIMEOUT;
    for (int j = 1; j <= TIMEOUT; j++) begin
      if (j == j_abort) kind = K_ABORT;
      else if (!op && j == j_zero) kind = K_ZERO;
      else if (j == j_stop) kind = K_STOP;
      if (kind != K_TOUT) begin
        e = j;
        break;
      end
    end
    exp_v[s] = pk(op, !op, op, 0, 1, 0, 0, 0);
    for (int j = 1; j <= e; j++) exp_v[s + j] = pk(0, 0, op, 0, 1, 0, 0, 0);
    case (kind)
      K_STOP: begin
        exp_v[s + e + 1] = pk(0, 0, op, 1, 1, 0, 0, 0);
        exp_v[s + e + 2] = pk(0, 0, op, 0, 1, 1, 0, 0);
        post = 2; kn = "load_done";
      end
      K_ZERO: begin
        exp_v[s + e + 1] = pk(0, 0, op, 0, 1, 0, 1, 0);
        post = 1; kn = "div_zero";
      end
      K_TOUT: begin
        exp_v[s + e + 1] = pk(0, 0, op, 0, 1, 0, 0, 1);
        post = 1; kn = "timeout";
      end
      default: begin
        post = 0; kn = "abort";
      end
    endcase
    next_cycle();
    busy_noise();
    for (int j = 1; j <= e; j++) begin
      next_cycle();
      req_mult = force_noise | rb();
      req_div  = force_noise | rb();
      abort    = (j == j_abort);
      if (op) begin
        mult_stop = (j == j_stop);
        div_stop  = force_noise | rb();
        div_zero  = rb();
      end else begin
        div_stop  = (j == j_stop);
        mult_stop = force_noise | rb();
        div_zero  = (j == j_zero);
      end
    end
    for (int p = 0; p < post; p++) begin
      next_cycle();
      busy_noise();
    end
    next_cycle();
    idle_noise();
    $display("txn req@%0d op=%s run_cycles=%0d outcome=%s", r, op ? "MULT" : "DIV", e, kn);
  endtask

  initial begin
    int r, r0, s;
    quiet();
    repeat (2) next_cycle();
    pin(cyc, 9'b000000000);
    next_cycle();
    reset = 1'b1;
    next_cycle();

    // MULT, stop 33 cycles after the start pulse
    r0 = cyc;
    pin(r0 + 1, 9'b101101000);
    pin(r0 + 2, 9'b001101000);
    pin(r0 + 35, 9'b001111000);
    pin(r0 + 36, 9'b001101100);
    pin(r0 + 37, 9'b000000000);
    run_txn(1, 0, 33, 0, 0, 0, 0, r);

    // DIV with zero divisor flagged on the first RUN cycle
    r0 = cyc;
    pin(r0 + 1, 9'b010001000);
    pin(r0 + 2, 9'b000001000);
    pin(r0 + 3, 9'b000001010);
    pin(r0 + 4, 9'b000000000);
    run_txn(0, 1, 0, 1, 0, 0, 0, r);

    // Simultaneous requests with stray div_stop and requests held during RUN
    r0 = cyc;
    pin(r0 + 1, 9'b101101000);
    pin(r0 + 3, 9'b001101000);
    pin(r0 + 7, 9'b001111000);
    pin(r0 + 8, 9'b001101100);
    pin(r0 + 9, 9'b000000000);
    run_txn(1, 1, 5, 0, 0, 1, 0, r);

    // DIV that never stops
    r0 = cyc;
    pin(r0 + 41, 9'b000001000);
    pin(r0 + 42, 9'b000001001);
    pin(r0 + 43, 9'b000000000);
    run_txn(0, 1, 0, 0, 0, 0, 0, r);

    // Reset dropped asynchronously mid RUN_DIV with counter at 10
    r0 = cyc;
    s = r0 + 1;
    quiet();
    req_div = 1;
    exp_v[s] = pk(0, 1, 0, 0, 1, 0, 0, 0);
    for (int j = 1; j <= 10; j++) exp_v[s + j] = pk(0, 0, 0, 0, 1, 0, 0, 0);
    pin(s + 10, 9'b000001000);
    pin(s + 11, 9'b000000000);
    next_cycle();
    quiet();
    for (int j = 1; j <= 11; j++) begin
      next_cycle();
      mult_stop = rb();
    end
    #2 reset = 1'b0;
    next_cycle();
    next_cycle();
    #3 reset = 1'b1;
    next_cycle();
    quiet();
    $display("txn req@%0d op=DIV run_cycles=11 outcome=reset", r0);

    r0 = cyc;
    pin(r0 + 6, 9'b001111000);
    pin(r0 + 7, 9'b001101100);
    run_txn(1, 0, 4, 0, 0, 0, 0, r);

    // Abort in RUN_MULT cycle 5 while req_div is held high
    r0 = cyc;
    pin(r0 + 6, 9'b001101000);
    pin(r0 + 7, 9'b000000000);
    pin(r0 + 8, 9'b000000000);
    pin(r0 + 9, 9'b000000000);
    run_txn(1, 0, 0, 0, 5, 1, 0, r);
    next_cycle();
    idle_noise();
    next_cycle();
    idle_noise();

    for (int t = 0; t < 40; t++) begin
      int sel, js, jz, ja;
      bit rm, rd;
      sel = int'($urandom_range(0, 2));
      rm = (sel != 1);
      rd = (sel != 0);
      js = (int'($urandom_range(0, 9)) < 7) ? int'($urandom_range(1, TIMEOUT)) : 0;
      jz = (rd && !rm && int'($urandom_range(0, 9)) < 3) ? int'($urandom_range(1, TIMEOUT)) : 0;
      ja = (int'($urandom_range(0, 9)) < 2) ? int'($urandom_range(1, TIMEOUT)) : 0;
      if ($urandom_range(0, 7) == 0) ja = js;
      run_txn(rm, rd, js, jz, ja, 0, int'($urandom_range(0, 3)), r);
    end

    quiet();
    repeat (3) next_cycle();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
